// File: rtl/alu_pkg.sv
// Shared encodings and the decoded-op bundle for the ALU decode pipe.
// cmd is funct[4:1]; alu_control selects the ALU operation.
package alu_pkg;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [3:0] ALU_ADD     = 4'b0000;
   localparam logic [3:0] ALU_SUB     = 4'b0001;
   localparam logic [3:0] ALU_AND     = 4'b0010;
   localparam logic [3:0] ALU_ORR     = 4'b0011;
   localparam logic [3:0] ALU_EOR     = 4'b0100;
   localparam logic [3:0] ALU_MOV     = 4'b0101;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

   localparam logic [1:0] FW_NONE = 2'b00;
   localparam logic [1:0] FW_NZ   = 2'b10;
   localparam logic [1:0] FW_NZCV = 2'b11;

   typedef struct packed {
      logic [3:0] alu_control;
      logic [1:0] flag_w;
      logic       illegal;
   } dec_op_t;

   localparam dec_op_t DEC_NOP = '{ALU_ADD, FW_NONE, 1'b0};

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational decode of alu_op/funct into a dec_op_t.
// Logical ops write NZ only; arithmetic ops write NZCV.
module alu_cmd_decode
   import alu_pkg::*;
#(
   parameter int FUNCT_W = 6
) (
   input  logic               alu_op,
   input  logic [FUNCT_W-1:0] funct,
   output dec_op_t            dec
);

   logic [3:0] cmd;
   logic       s;
   logic       unused_hi;

   assign cmd       = funct[4:1];
   assign s         = funct[0];
   assign unused_hi = ^funct[FUNCT_W-1:5];

   always_comb begin
      dec = DEC_NOP;
      if (alu_op) begin
         case (cmd)
            CMD_ADD: dec = '{ALU_ADD, s ? FW_NZCV : FW_NONE, 1'b0};
            CMD_SUB: dec = '{ALU_SUB, s ? FW_NZCV : FW_NONE, 1'b0};
            CMD_AND: dec = '{ALU_AND, s ? FW_NZ : FW_NONE, 1'b0};
            CMD_ORR: dec = '{ALU_ORR, s ? FW_NZ : FW_NONE, 1'b0};
            CMD_EOR: dec = '{ALU_EOR, s ? FW_NZ : FW_NONE, 1'b0};
            CMD_MOV: dec = '{ALU_MOV, s ? FW_NZ : FW_NONE, 1'b0};
            CMD_CMP: dec = '{ALU_SUB, FW_NZCV, 1'b0};
            default: dec = '{ALU_ILLEGAL, FW_NONE, 1'b1};
         endcase
      end
   end

endmodule

// File: rtl/alu_decode_pipe.sv
// Decoded-op buffer with NZCV flag register and illegal-op counter.
// All outputs come from registers; head fields read zero when empty.
module alu_decode_pipe
   import alu_pkg::*;
#(
   parameter int FUNCT_W = 6,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               alu_op,
   input  logic [FUNCT_W-1:0] funct,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         alu_control,
   output logic [1:0]         flag_w,
   output logic               illegal,
   input  logic [3:0]         alu_flags_in,
   output logic [3:0]         flags,
   output logic [CNT_W-1:0]   illegal_cnt
);

   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   dec_op_t       dec;
   dec_op_t       head;
   dec_op_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push;
   logic          pop;

   alu_cmd_decode #(.FUNCT_W(FUNCT_W)) u_dec (
      .alu_op (alu_op),
      .funct  (funct),
      .dec    (dec)
   );

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign head        = out_valid ? mem[rd_ptr] : '0;
   assign alu_control = head.alu_control;
   assign flag_w      = head.flag_w;
   assign illegal     = head.illegal;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         flags       <= '0;
         illegal_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Illegal ops never touch the flags; they only bump the counter.
         if (pop) begin
            if (head.illegal) begin
               if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
            end else begin
               if (head.flag_w[1]) flags[3:2] <= alu_flags_in[3:2];
               if (head.flag_w[0]) flags[1:0] <= alu_flags_in[1:0];
            end
         end
      end
   end

endmodule
